// File: rtl/hex_display_scanner.sv
// Scan controller for a common-anode multi-digit seven-segment display.
// Presents one nibble per slot to the decoder and lights the matching digit after an all-off gap.
module hex_display_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   valueIn,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blankMask,
  input  logic                  zeroSuppress,
  output logic [3:0]            hexOut,
  output logic [DIGITS-1:0]     digitEnable,
  output logic                  frameTick
);

  localparam int PH_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DSEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(REFRESH_DIV - 1);
  localparam logic [PH_W-1:0]   PH_GAP   = PH_W'(GAP_CYCLES);
  localparam logic [DSEL_W-1:0] DIG_LAST = DSEL_W'(DIGITS - 1);

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [DSEL_W-1:0]     digit_sel_q, digit_sel_d;
  logic [4*DIGITS-1:0]   value_reg_q, value_reg_d;
  logic [3:0]            slot_nibble_q, slot_nibble_d;
  logic                  slot_visible_q, slot_visible_d;
  logic [3:0]            hex_out_q, hex_out_d;
  logic [DIGITS-1:0]     digit_enable_q, digit_enable_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  slot_start;
  logic                  slot_wrap;
  logic [DIGITS-1:0]     lead_zero;

  // Slot timing: the first edge out of reset opens digit 0's slot, later slots open on phase wrap.
  always_comb begin
    slot_wrap   = armed_q && (phase_q == PH_LAST);
    slot_start  = !armed_q || slot_wrap;
    armed_d     = 1'b1;
    phase_d     = slot_start ? '0 : phase_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (!armed_q) begin
      digit_sel_d = '0;
    end else if (slot_wrap) begin
      digit_sel_d = (digit_sel_q == DIG_LAST) ? '0 : digit_sel_q + 1'b1;
    end
  end

  always_comb begin
    value_reg_d = load ? valueIn : value_reg_q;
  end

  // lead_zero[i] is set when nibbles DIGITS-1 down to i of the held value are all zero.
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run && (value_reg_q[4*i +: 4] == 4'h0);
      lead_zero[i] = run;
    end
  end

  // Slot capture uses the pre-edge value so a coincident load only shows from the next slot.
  always_comb begin
    slot_nibble_d  = slot_nibble_q;
    slot_visible_d = slot_visible_q;
    if (slot_start) begin
      slot_nibble_d  = value_reg_q[4*digit_sel_d +: 4];
      slot_visible_d = !blankMask[digit_sel_d] &&
                       !(zeroSuppress && (digit_sel_d != '0) && lead_zero[digit_sel_d]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GAP;
      armed_q     <= 1'b0;
      phase_q     <= '0;
      digit_sel_q <= '0;
      value_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      phase_q     <= phase_d;
      digit_sel_q <= digit_sel_d;
      value_reg_q <= value_reg_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_nibble_q  <= slot_nibble_d;
    slot_visible_q <= slot_visible_d;
  end

  always_comb begin
    state_d = state_q;
    if (slot_start) begin
      state_d = GAP;
    end else if (phase_d == PH_GAP) begin
      state_d = SHOW;
    end
  end

  // Outputs are computed from next-state values so the registered outputs line up with phase/digit.
  always_comb begin
    hex_out_d      = slot_nibble_d;
    digit_enable_d = '1;
    frame_tick_d   = slot_start && (digit_sel_d == '0);
    if (state_d == SHOW && slot_visible_d) begin
      digit_enable_d[digit_sel_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_out_q      <= 4'h0;
      digit_enable_q <= '1;
      frame_tick_q   <= 1'b0;
    end else begin
      hex_out_q      <= hex_out_d;
      digit_enable_q <= digit_enable_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign hexOut      = hex_out_q;
  assign digitEnable = digit_enable_q;
  assign frameTick   = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner, compared cycle by cycle against a
// slot-arithmetic reference model (slot index and phase derived from the edge count).
module tb_hex_display_scanner;

  localparam int D = 4;
  localparam int R = 8;
  localparam int G = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   valueIn;
  logic          load;
  logic [3:0]    blankMask;
  logic          zeroSuppress;
  logic [3:0]    hexOut;
  logic [3:0]    digitEnable;
  logic          frameTick;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          n = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_nib = '0;
  logic        m_vis = 1'b0;
  logic [3:0]  exp_hex;
  logic [3:0]  exp_en;
  logic        exp_tick;

  logic [3:0]  cur_mask = '0;
  logic        cur_zs   = 1'b0;

  hex_display_scanner #(
    .DIGITS      (D),
    .REFRESH_DIV (R),
    .GAP_CYCLES  (G)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valueIn      (valueIn),
    .load         (load),
    .blankMask    (blankMask),
    .zeroSuppress (zeroSuppress),
    .hexOut       (hexOut),
    .digitEnable  (digitEnable),
    .frameTick    (frameTick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  // Model one rising edge from the rules: slot p/d from edge count, capture at p==0 with pre-edge value.
  task automatic model_edge(input logic r, input logic ld, input logic [15:0] v,
                            input logic [3:0] mk, input logic z);
    int p;
    int d;
    logic [3:0] e;
    if (r) begin
      n        = 0;
      m_val    = '0;
      exp_hex  = 4'h0;
      exp_en   = 4'hF;
      exp_tick = 1'b0;
    end else begin
      n++;
      p = (n - 1) % R;
      d = ((n - 1) / R) % D;
      if (p == 0) begin
        m_nib = 4'((m_val >> (4 * d)) & 16'hF);
        m_vis = !mk[d] && !(z && d != 0 && ((m_val >> (4 * d)) == 16'h0));
      end
      if (ld) m_val = v;
      e = 4'hF;
      if (p >= G && m_vis) e[d] = 1'b0;
      exp_hex  = m_nib;
      exp_en   = e;
      exp_tick = (p == 0 && d == 0);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] mk, input logic z);
    reset        = r;
    load         = ld;
    valueIn      = v;
    blankMask    = mk;
    zeroSuppress = z;
    @(posedge clk);
    model_edge(r, ld, v, mk, z);
    #1;
    check_eq("hexOut", 32'(hexOut), 32'(exp_hex));
    check_eq("digitEnable", 32'(digitEnable), 32'(exp_en));
    check_eq("frameTick", 32'(frameTick), 32'(exp_tick));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'h0, cur_mask, cur_zs);
  endtask

  // advance until the state after the most recent edge is phase p of digit d
  task automatic idle_until(input int p, input int d);
    for (int i = 0; i < 4 * D * R; i++) begin
      if (n > 0 && ((n - 1) % R) == p && (((n - 1) / R) % D) == d) break;
      idle(1);
    end
  endtask

  initial begin
    logic [15:0] rv;
    logic [15:0] nmask;
    // reset with load held high: value must stay zero
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h1A2F, 4'h0, 1'b0);
    idle(2 * D * R);

    // basic scan: load on the first edge out of reset, full frame afterwards
    step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h1A2F, cur_mask, cur_zs);
    idle(2 * D * R + 4);

    // leading-zero suppression
    cur_zs = 1'b1;
    step(1'b0, 1'b1, 16'h0050, cur_mask, cur_zs);
    idle(2 * D * R);
    step(1'b0, 1'b1, 16'h0000, cur_mask, cur_zs);
    idle(2 * D * R);
    step(1'b0, 1'b1, 16'h0300, cur_mask, cur_zs);
    idle(D * R + 3);
    cur_zs = 1'b0;

    // load coinciding with the start of digit 1's slot
    step(1'b0, 1'b1, 16'h1234, cur_mask, cur_zs);
    idle_until(R - 1, 0);
    step(1'b0, 1'b1, 16'hBEEF, cur_mask, cur_zs);
    idle(2 * D * R);

    // blank mask changed mid-slot of digit 2
    idle_until(4, 2);
    cur_mask = 4'b0100;
    idle(2 * D * R);
    cur_mask = 4'b0000;

    // reset during digit 2's SHOW phase
    idle_until(G + 1, 2);
    step(1'b1, 1'b0, 16'h0, cur_mask, cur_zs);
    idle(D * R + 2);

    // randomized traffic with sparse nibbles and occasional resets
    for (int i = 0; i < 1500; i++) begin
      nmask = {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
               {4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}}};
      rv = 16'($urandom) & nmask;
      if ($urandom_range(0, 15) == 0) cur_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cur_zs = 1'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, rv, cur_mask, cur_zs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
